mem_stage_ctrl: RTL

- Memory-access stage of the pipeline; sits directly upstream of the writeback data mux.
- Accepts one operation at a time from execute. ALU-only ops pass through. Loads and stores run a req/ack handshake with a variable-latency data memory.
- Produces the mux operands (mem_data, calc, sel_dat) plus a register-file write strobe, all as registered outputs.
- Times out hung memory accesses.

---
 rtl/mem_stage_ctrl.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/mem_stage_ctrl.sv
// Memory-access pipeline stage: passes ALU results through, runs loads/stores over a
// req/ack data-memory handshake with a timeout, and registers the writeback-mux operands.
module mem_stage_ctrl #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int REG_W   = 5,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [DATA_W-1:0] ex_calc,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic              ex_is_load,
  input  logic              ex_is_store,
  input  logic [REG_W-1:0]  ex_rd,
  input  logic              ex_wr_en,
  output logic              dm_req,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic              dm_ack,
  input  logic [DATA_W-1:0] dm_rdata,
  output logic              wb_valid,
  output logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] calc,
  output logic              sel_dat,
  output logic [REG_W-1:0]  wb_rd,
  output logic              wb_wr_en,
  output logic              bus_err,
  output logic              dbg_state
);

  // Handshake: ex side transfers when ex_valid & ex_ready at a rising edge; the memory
  // holds dm_req/dm_we/dm_addr/dm_wdata stable until a one-cycle dm_ack or the timeout.
  typedef enum logic {IDLE = 1'b0, MEM_WAIT = 1'b1} state_e;

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                dm_req_q, dm_req_d;
  logic                dm_we_q, dm_we_d;
  logic [ADDR_W-1:0]   dm_addr_q, dm_addr_d;
  logic [DATA_W-1:0]   dm_wdata_q, dm_wdata_d;
  logic                wb_valid_q, wb_valid_d;
  logic [DATA_W-1:0]   mem_data_q, mem_data_d;
  logic [DATA_W-1:0]   calc_q, calc_d;
  logic                sel_dat_q, sel_dat_d;
  logic [REG_W-1:0]    wb_rd_q, wb_rd_d;
  logic                wb_wr_en_q, wb_wr_en_d;
  logic                bus_err_q, bus_err_d;
  logic [REG_W-1:0]    rd_lat_q, rd_lat_d;
  logic                wr_lat_q, wr_lat_d;
  logic                load_lat_q, load_lat_d;

  assign ex_ready  = (state_q == IDLE) && !rst;
  assign dm_req    = dm_req_q;
  assign dm_we     = dm_we_q;
  assign dm_addr   = dm_addr_q;
  assign dm_wdata  = dm_wdata_q;
  assign wb_valid  = wb_valid_q;
  assign mem_data  = mem_data_q;
  assign calc      = calc_q;
  assign sel_dat   = sel_dat_q;
  assign wb_rd     = wb_rd_q;
  assign wb_wr_en  = wb_wr_en_q;
  assign bus_err   = bus_err_q;
  assign dbg_state = state_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dm_req_d   = dm_req_q;
    dm_we_d    = dm_we_q;
    dm_addr_d  = dm_addr_q;
    dm_wdata_d = dm_wdata_q;
    wb_valid_d = 1'b0;
    mem_data_d = mem_data_q;
    calc_d     = calc_q;
    sel_dat_d  = sel_dat_q;
    wb_rd_d    = wb_rd_q;
    wb_wr_en_d = 1'b0;
    bus_err_d  = bus_err_q;
    rd_lat_d   = rd_lat_q;
    wr_lat_d   = wr_lat_q;
    load_lat_d = load_lat_q;
    case (state_q)
      IDLE: begin
        if (ex_valid) begin
          calc_d = ex_calc;
          if (ex_is_load || ex_is_store) begin
            // Load wins when both type bits are set.
            dm_req_d   = 1'b1;
            dm_we_d    = ex_is_store && !ex_is_load;
            dm_addr_d  = ex_calc[ADDR_W-1:0];
            dm_wdata_d = ex_store_data;
            rd_lat_d   = ex_rd;
            wr_lat_d   = ex_wr_en;
            load_lat_d = ex_is_load;
            cnt_d      = '0;
            state_d    = MEM_WAIT;
          end else begin
            wb_valid_d = 1'b1;
            sel_dat_d  = 1'b1;
            wb_rd_d    = ex_rd;
            wb_wr_en_d = ex_wr_en;
          end
        end
      end
      MEM_WAIT: begin
        if (dm_ack) begin
          dm_req_d   = 1'b0;
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_lat_q;
          state_d    = IDLE;
          if (load_lat_q) begin
            mem_data_d = dm_rdata;
            sel_dat_d  = 1'b0;
            wb_wr_en_d = wr_lat_q;
          end else begin
            sel_dat_d  = 1'b1;
          end
        end else if (cnt_q == CNT_LAST) begin
          // Request has been up TIMEOUT cycles: give up and retire without a write.
          dm_req_d   = 1'b0;
          bus_err_d  = 1'b1;
          wb_valid_d = 1'b1;
          state_d    = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      dm_req_q   <= 1'b0;
      dm_we_q    <= 1'b0;
      dm_addr_q  <= '0;
      dm_wdata_q <= '0;
      wb_valid_q <= 1'b0;
      mem_data_q <= '0;
      calc_q     <= '0;
      sel_dat_q  <= 1'b0;
      wb_rd_q    <= '0;
      wb_wr_en_q <= 1'b0;
      bus_err_q  <= 1'b0;
      rd_lat_q   <= '0;
      wr_lat_q   <= 1'b0;
      load_lat_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dm_req_q   <= dm_req_d;
      dm_we_q    <= dm_we_d;
      dm_addr_q  <= dm_addr_d;
      dm_wdata_q <= dm_wdata_d;
      wb_valid_q <= wb_valid_d;
      mem_data_q <= mem_data_d;
      calc_q     <= calc_d;
      sel_dat_q  <= sel_dat_d;
      wb_rd_q    <= wb_rd_d;
      wb_wr_en_q <= wb_wr_en_d;
      bus_err_q  <= bus_err_d;
      rd_lat_q   <= rd_lat_d;
      wr_lat_q   <= wr_lat_d;
      load_lat_q <= load_lat_d;
    end
  end

endmodule
